// File: rtl/pr_ifid_skid_pkg.sv
// Shared MIPS32 fetch/decode constants and the IF/ID skid-buffer state type.
package pr_ifid_skid_pkg;

  localparam int unsigned ISA_DATA_W = 32;
  localparam int unsigned ISA_NUM_W  = 4;

  localparam logic [ISA_DATA_W-1:0] NOP_INST = 32'h0000_0000;

  localparam logic [ISA_NUM_W-1:0] INST_TYPE_ALU    = 4'h0;
  localparam logic [ISA_NUM_W-1:0] INST_TYPE_LOAD   = 4'h1;
  localparam logic [ISA_NUM_W-1:0] INST_TYPE_STORE  = 4'h2;
  localparam logic [ISA_NUM_W-1:0] INST_TYPE_BRANCH = 4'h3;
  localparam logic [ISA_NUM_W-1:0] INST_TYPE_JUMP   = 4'h4;
  localparam logic [ISA_NUM_W-1:0] INST_TYPE_NONE   = 4'hF;

  // Encoding is chosen so the state value equals the number of valid entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ifid_state_t;

  function automatic logic [1:0] occ_of(input ifid_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pr_ifid_skid_slot.sv
// One IF/ID payload register set with a valid bit; clear returns it to a bubble.
module ifid_slot #(
  parameter int unsigned      W         = 8,
  parameter logic [W-1:0]     EMPTY_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= EMPTY_VAL;
    end else if (clr) begin
      valid <= 1'b0;
      q     <= EMPTY_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pr_ifid_skid.sv
// IF/ID pipeline register: two-entry skid buffer with valid/ready handshake and branch flush.
module pr_ifid_skid
  import pr_ifid_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_newpc,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [NUM_W-1:0]  in_instnum,
  input  logic [NUM_W-1:0]  in_insttype,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_newpc,
  output logic [DATA_W-1:0] out_inst,
  output logic [NUM_W-1:0]  out_instnum,
  output logic [NUM_W-1:0]  out_insttype,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned PAY_W = 3 * DATA_W + 2 * NUM_W;
  localparam logic [PAY_W-1:0] EMPTY_PAY = {DATA_W'(0), DATA_W'(0), DATA_W'(NOP_INST),
                                            NUM_W'(0), NUM_W'(INST_TYPE_NONE)};

  ifid_state_t      state, state_nxt;
  logic             accept, pop;
  logic             main_load, main_from_skid, main_clr;
  logic             skid_load, skid_clr, skid_valid;
  logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
  logic [CNT_W:0]   fc_sum;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign in_pay = {in_pc, in_newpc, in_inst, in_instnum, in_insttype};
  assign main_d = main_from_skid ? skid_q : in_pay;
  assign fc_sum = {1'b0, flush_count} + (CNT_W+1)'(occupancy);

  // Next-state and slot control; flush overrides any handshake.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && accept) begin
            main_load = 1'b1;
          end else if (pop) begin
            main_clr  = 1'b1;
            state_nxt = ST_EMPTY;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nxt = ST_TWO;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_EMPTY;
      occupancy   <= 2'd0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      occupancy <= occ_of(state_nxt);
      if (flush) begin
        flush_count <= fc_sum[CNT_W] ? {CNT_W{1'b1}} : fc_sum[CNT_W-1:0];
      end
    end
  end

  ifid_slot #(.W(PAY_W), .EMPTY_VAL(EMPTY_PAY)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .valid (out_valid),
    .q     (main_q)
  );

  ifid_slot #(.W(PAY_W), .EMPTY_VAL(EMPTY_PAY)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clr   (skid_clr),
    .d     (in_pay),
    .valid (skid_valid),
    .q     (skid_q)
  );

  // Main slot is cleared to a bubble whenever it empties, so it drives decode directly.
  assign {out_pc, out_newpc, out_inst, out_instnum, out_insttype} = main_q;
  assign in_ready = ~skid_valid;

endmodule

// File: tb/tb_pr_ifid_skid.sv
// Self-checking bench for pr_ifid_skid against a two-deep FIFO reference model.
module tb_pr_ifid_skid;
  import pr_ifid_skid_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] newpc;
    logic [31:0] inst;
    logic [3:0]  num;
    logic [3:0]  typ;
  } bund_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_pc = '0, in_newpc = '0, in_inst = '0;
  logic [3:0]  in_instnum = '0, in_insttype = '0;
  logic [31:0] out_pc, out_newpc, out_inst;
  logic [3:0]  out_instnum, out_insttype;
  logic [1:0]  occupancy;
  logic [7:0]  flush_count;
  logic [115:0] act;

  int checks = 0;
  int failures = 0;
  bund_t mq[$];
  int mfc = 0;

  always #5 clock = ~clock;

  pr_ifid_skid #(.DATA_W(32), .NUM_W(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_newpc(in_newpc), .in_inst(in_inst),
    .in_instnum(in_instnum), .in_insttype(in_insttype), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_newpc(out_newpc), .out_inst(out_inst), .out_instnum(out_instnum),
    .out_insttype(out_insttype), .occupancy(occupancy), .flush_count(flush_count)
  );

  assign act = {out_valid, in_ready, occupancy, flush_count,
                out_pc, out_newpc, out_inst, out_instnum, out_insttype};

  function automatic logic [115:0] exp_vec();
    bund_t h;
    h = '{pc: 32'h0, newpc: 32'h0, inst: NOP_INST, num: 4'h0, typ: INST_TYPE_NONE};
    if (mq.size() > 0) h = mq[0];
    return {1'(mq.size() > 0), 1'(mq.size() < 2), 2'(mq.size()), 8'(mfc), h};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] num);
    in_valid    = v;
    in_pc       = pc;
    in_newpc    = pc + 32'd4;
    in_inst     = $urandom;
    in_instnum  = num;
    in_insttype = 4'($urandom_range(0, 14));
  endtask

  // Advance the reference FIFO with the inputs presented at this edge, then step the clock.
  task automatic tick();
    bund_t b;
    bit acc, pp;
    b = {in_pc, in_newpc, in_inst, in_instnum, in_insttype};
    if (!reset) begin
      mq.delete();
      mfc = 0;
    end else if (flush) begin
      mfc = (mfc + mq.size() > 255) ? 255 : mfc + mq.size();
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (act !== exp_vec()) begin failures++; $display("FAIL reset_initial act=%h exp=%h", act, exp_vec()); end
    drive(1'b1, 32'h40, 4'h1); tick();
    drive(1'b1, 32'h44, 4'h2); tick();
    flush = 1'b1; in_valid = 1'b0; tick(); flush = 1'b0;
    checks++; if (flush_count !== 8'd2) begin failures++; $display("FAIL reset_pre_fc act=%0d exp=2", flush_count); end
    drive(1'b1, 32'h48, 4'h3); tick();
    drive(1'b1, 32'h4c, 4'h4); tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL reset_pre_occ act=%0d exp=2", occupancy); end
    // Reset while stalled, with flush and a handshake all active.
    reset = 1'b0; flush = 1'b1; out_ready = 1'b1; drive(1'b1, 32'h50, 4'h5);
    tick();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid act=%0d exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready act=%0d exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ act=%0d exp=0", occupancy); end
    checks++; if (out_insttype !== INST_TYPE_NONE) begin failures++; $display("FAIL reset_type act=%h exp=%h", out_insttype, INST_TYPE_NONE); end
    checks++; if (flush_count !== 8'd0) begin failures++; $display("FAIL reset_fc act=%0d exp=0", flush_count); end
    checks++; if ({out_pc, out_newpc, out_inst, out_instnum} !== 100'h0) begin failures++; $display("FAIL reset_payload act=%h exp=0", {out_pc, out_newpc, out_inst, out_instnum}); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 4'(i));
      tick();
      checks++; if (out_instnum !== 4'(i)) begin failures++; $display("FAIL stream_num act=%0d exp=%0d", out_instnum, i); end
      checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin failures++; $display("FAIL stream_ready_occ act=%0d/%0d exp=1/1", in_ready, occupancy); end
      checks++; if (act !== exp_vec()) begin failures++; $display("FAIL stream_model act=%h exp=%h", act, exp_vec()); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin failures++; $display("FAIL stream_drain act=%0d/%h exp=0/0", out_valid, out_inst); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 32'h10, 4'hA); tick();
    drive(1'b1, 32'h11, 4'hB); tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_full act=%0d/%0d exp=2/0", occupancy, in_ready); end
    drive(1'b1, 32'h12, 4'hC); tick();
    checks++; if (occupancy !== 2'd2 || out_pc !== 32'h10) begin failures++; $display("FAIL stall_ignore act=%0d/%h exp=2/10", occupancy, out_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h11 || in_ready !== 1'b1 || occupancy !== 2'd1) begin failures++; $display("FAIL stall_popA act=%h/%0d/%0d exp=11/1/1", out_pc, in_ready, occupancy); end
    tick();
    checks++; if (out_pc !== 32'h12 || out_instnum !== 4'hC) begin failures++; $display("FAIL stall_C act=%h/%h exp=12/c", out_pc, out_instnum); end
    checks++; if (act !== exp_vec()) begin failures++; $display("FAIL stall_model act=%h exp=%h", act, exp_vec()); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain act=%0d exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h20, 4'h1); tick();
    drive(1'b1, 32'h24, 4'h2); tick();
    drive(1'b1, 32'h99, 4'h9); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_inst !== 32'h0) begin failures++; $display("FAIL flush_empty act=%0d/%0d/%h exp=0/0/0", out_valid, occupancy, out_inst); end
    checks++; if (flush_count !== 8'd2 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_count act=%0d/%0d exp=2/1", flush_count, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_pc === 32'h99) begin failures++; $display("FAIL flush_dropped act=%0d/%h exp=0/0", out_valid, out_pc); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (127) begin
      drive(1'b1, 32'h300, 4'h1); tick();
      drive(1'b1, 32'h304, 4'h2); tick();
      in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    end
    checks++; if (flush_count !== 8'd254) begin failures++; $display("FAIL sat_preload act=%0d exp=254", flush_count); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (flush_count !== 8'd254 || occupancy !== 2'd0) begin failures++; $display("FAIL sat_empty_flush act=%0d/%0d exp=254/0", flush_count, occupancy); end
    drive(1'b1, 32'h308, 4'h3); tick();
    drive(1'b1, 32'h30c, 4'h4); tick();
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (flush_count !== 8'd255) begin failures++; $display("FAIL sat_255 act=%0d exp=255", flush_count); end
    drive(1'b1, 32'h310, 4'h5); tick();
    in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (flush_count !== 8'd255) begin failures++; $display("FAIL sat_hold act=%0d exp=255", flush_count); end
  endtask

  task automatic test_pop_accept();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h200, 4'hE); tick();
    checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL popacc_first act=%h exp=200", out_pc); end
    drive(1'b1, 32'h204, 4'hF); tick();
    checks++; if (out_pc !== 32'h204 || out_instnum !== 4'hF || occupancy !== 2'd1) begin failures++; $display("FAIL popacc_replace act=%h/%h/%0d exp=204/f/1", out_pc, out_instnum, occupancy); end
    drive(1'b1, 32'h208, 4'h0); tick();
    checks++; if (out_instnum !== 4'h0 || out_newpc !== 32'h20c) begin failures++; $display("FAIL popacc_wrap act=%h/%h exp=0/20c", out_instnum, out_newpc); end
    checks++; if (act !== exp_vec()) begin failures++; $display("FAIL popacc_model act=%h exp=%h", act, exp_vec()); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) != 0);
      tick();
      checks++; if (act !== exp_vec()) begin failures++; $display("FAIL random_cycle%0d act=%h exp=%h", i, act, exp_vec()); end
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturation();
    test_pop_accept();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
